// File: rtl/chip8_timer_bank_pkg.sv
// chip8_timer_bank_pkg
//   Shared constants for the CHIP-8 timer bank: channel assignments, the
//   nominal tick rate and counter width, plus the prescaler divide helper.
//   Imported by chip8_timer_bank and timer_prescaler.
package chip8_timer_bank_pkg;

    localparam int unsigned CHIP8_DT_CH   = 0;
    localparam int unsigned CHIP8_ST_CH   = 1;
    localparam int unsigned CHIP8_TICK_HZ = 60;
    localparam int unsigned CHIP8_TIMER_W = 8;

    typedef enum int unsigned {
        CH_DT = CHIP8_DT_CH,
        CH_ST = CHIP8_ST_CH
    } chip8_ch_e;

    // Clocks per timer tick; integer divide, evaluated at elaboration.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler
//   Free-running divider counting 0..DIV-1 while en is high. tick is a
//   registered one-cycle pulse in the cycle after the count wraps.
//   With CLR_IDLE set, en low also clears the count (used for the tone
//   divider so every burst starts from 0); otherwise en low holds it.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   en   - count enable
//   tick - wrap pulse (registered)
module timer_prescaler
    import chip8_timer_bank_pkg::*;
#(
    parameter int unsigned DIV      = 2,
    parameter bit          CLR_IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned  W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
            if (CLR_IDLE) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/chip8_timer_bank.sv
// chip8_timer_bank
//   Bank of NUM_CH CHIP-8 countdown timers decremented at TICK_HZ.
//   Channel 0 is the delay timer, channel 1 the sound timer.
//   Optional tone output enabled by defining CHIP8_TIMER_TONE_EN; when
//   undefined the tone logic is absent and tone_o is tied low.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   en              - prescaler enable (low freezes ticks and decrements)
//   ld_en/ld_sel/ld_val - one-cycle load of a channel counter
//   rd_en/rd_sel    - read request; rd_q/rd_v return data one cycle later
//   tick_o          - one-cycle pulse per prescaler wrap
//   nz_o            - per-channel counter-non-zero flags
//   tone_o          - square wave while channel TONE_CH is non-zero
module chip8_timer_bank
    import chip8_timer_bank_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned CNT_W    = CHIP8_TIMER_W,
    parameter int unsigned CLK_HZ   = 25000000,
    parameter int unsigned TICK_HZ  = CHIP8_TICK_HZ,
    parameter int unsigned TONE_CH  = CHIP8_ST_CH,
    parameter int unsigned TONE_DIV = 28409,
    localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ld_en,
    input  logic [SEL_W-1:0]  ld_sel,
    input  logic [CNT_W-1:0]  ld_val,
    input  logic              rd_en,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_q,
    output logic              rd_v,
    output logic              tick_o,
    output logic [NUM_CH-1:0] nz_o,
    output logic              tone_o
);

    localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);

    logic             tick;
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [CNT_W-1:0] rd_mux;

    timer_prescaler #(
        .DIV      (DIV),
        .CLR_IDLE (1'b0)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // Decrements are applied on the edge where the registered tick is high.
    assign tick_o = tick;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            nz_o[i] = (cnt[i] != '0);
        end
    end

    // Out-of-range selects match no channel and read back as 0.
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_mux = cnt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            rd_q <= '0;
            rd_v <= 1'b0;
        end else begin
            // Load wins over a same-edge decrement; out-of-range ld_sel
            // matches no channel and is dropped.
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (ld_en && (ld_sel == SEL_W'(i))) begin
                    cnt[i] <= ld_val;
                end else if (tick && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
            rd_v <= rd_en;
            if (rd_en) begin
                rd_q <= rd_mux;
            end
        end
    end

`ifdef CHIP8_TIMER_TONE_EN
    logic tone_tick;

    timer_prescaler #(
        .DIV      (TONE_DIV),
        .CLR_IDLE (1'b1)
    ) u_tone (
        .clk  (clk),
        .rst  (rst),
        .en   (nz_o[TONE_CH]),
        .tick (tone_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_o <= 1'b0;
        end else if (!nz_o[TONE_CH]) begin
            tone_o <= 1'b0;
        end else if (tone_tick) begin
            tone_o <= ~tone_o;
        end
    end
`else
    assign tone_o = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_timer_bank.sv
// tb_chip8_timer_bank
//   Self-checking bench for chip8_timer_bank with CLK_HZ=600, TICK_HZ=60
//   (DIV=10), TONE_DIV=3, NUM_CH=2. A cycle-level reference model tracks
//   enabled-edge counts and integer counters; fixed tables and directed
//   sequences cover loads, reads, ticks, freeze, reset and tone.
module tb_chip8_timer_bank;

    localparam int DIV      = 10;
    localparam int TONE_DIV = 3;
`ifdef CHIP8_TIMER_TONE_EN
    localparam bit TONE_ON = 1'b1;
`else
    localparam bit TONE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ld_en;
    logic [0:0] ld_sel;
    logic [7:0] ld_val;
    logic       rd_en;
    logic [0:0] rd_sel;
    logic [7:0] rd_q;
    logic       rd_v;
    logic       tick_o;
    logic [1:0] nz_o;
    logic       tone_o;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int m_cnt [2];
    int m_en_edges;
    bit m_tick;
    int m_rdq;
    bit m_rdv;
    int m_run;
    bit m_tone;

    chip8_timer_bank #(
        .NUM_CH   (2),
        .CNT_W    (8),
        .CLK_HZ   (600),
        .TICK_HZ  (60),
        .TONE_CH  (1),
        .TONE_DIV (TONE_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .ld_en  (ld_en),
        .ld_sel (ld_sel),
        .ld_val (ld_val),
        .rd_en  (rd_en),
        .rd_sel (rd_sel),
        .rd_q   (rd_q),
        .rd_v   (rd_v),
        .tick_o (tick_o),
        .nz_o   (nz_o),
        .tone_o (tone_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt[0]   = 0;
        m_cnt[1]   = 0;
        m_en_edges = 0;
        m_tick     = 1'b0;
        m_rdq      = 0;
        m_rdv      = 1'b0;
        m_run      = 0;
        m_tone     = 1'b0;
    endtask

    // One rising edge of the reference behaviour, using pre-edge values.
    task automatic model_edge();
        int old [2];
        old = m_cnt;
        if (old[1] == 0) begin
            m_run  = 0;
            m_tone = 1'b0;
        end else begin
            m_run++;
            m_tone = TONE_ON && ((((m_run - 1) / TONE_DIV) % 2) == 1);
        end
        for (int ch = 0; ch < 2; ch++) begin
            if (ld_en && int'(ld_sel) == ch)
                m_cnt[ch] = int'(ld_val);
            else if (m_tick && old[ch] > 0)
                m_cnt[ch] = old[ch] - 1;
        end
        if (rd_en) m_rdq = old[int'(rd_sel)];
        m_rdv = rd_en;
        if (en) m_en_edges++;
        m_tick = en && (m_en_edges % DIV == 0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rd_q"},   rd_q,   m_rdq);
        chk({tag, ".rd_v"},   rd_v,   m_rdv);
        chk({tag, ".tick_o"}, tick_o, m_tick);
        chk({tag, ".nz_o"},   nz_o,   {m_cnt[1] != 0, m_cnt[0] != 0});
        chk({tag, ".tone_o"}, tone_o, m_tone);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic set_idle();
        en     = 1'b0;
        ld_en  = 1'b0;
        ld_sel = '0;
        ld_val = '0;
        rd_en  = 1'b0;
        rd_sel = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        model_reset();
        #1;
        check_model("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       ld_en;
        logic       ld_sel;
        logic [7:0] ld_val;
        logic       rd_en;
        logic       rd_sel;
        logic [7:0] q;
        logic       v;
        logic [1:0] nz;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int n;
        int first_tick, second_tick, nz_fall, ticks, rises;
        logic prev_tone;

        rst = 1'b1;
        set_idle();
        model_reset();

        // ---- table: loads and reads with the prescaler frozen ----
        tbl[0] = '{1'b1, 1'b0, 8'd7, 1'b0, 1'b0, 8'd0, 1'b0, 2'b01};
        tbl[1] = '{1'b1, 1'b0, 8'd9, 1'b1, 1'b0, 8'd7, 1'b1, 2'b01};
        tbl[2] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd9, 1'b1, 2'b01};
        tbl[3] = '{1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 8'd0, 1'b1, 2'b11};
        tbl[4] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b11};
        tbl[5] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 1'b1, 2'b11};
        tbl[6] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5, 1'b0, 2'b10};
        tbl[7] = '{1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 2'b00};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ld_en  = tbl[i].ld_en;
            ld_sel = tbl[i].ld_sel;
            ld_val = tbl[i].ld_val;
            rd_en  = tbl[i].rd_en;
            rd_sel = tbl[i].rd_sel;
            cycle("tbl");
            chk("tbl.rd_q",   rd_q,   tbl[i].q);
            chk("tbl.rd_v",   rd_v,   tbl[i].v);
            chk("tbl.nz_o",   nz_o,   tbl[i].nz);
            chk("tbl.tick_o", tick_o, 1'b0);
        end

        // ---- countdown 3,2,1,0 and tick period ----
        do_reset();
        en = 1'b1;
        first_tick = 0; second_tick = 0; nz_fall = 0;
        for (int e = 1; e <= 45; e++) begin
            ld_en = (e == 1); ld_sel = 1'b0; ld_val = 8'd3;
            rd_en = 1'b1; rd_sel = 1'b0;
            cycle("count");
            if (tick_o) begin
                if (first_tick == 0) first_tick = e;
                else if (second_tick == 0) second_tick = e;
            end
            if (nz_fall == 0 && e > 1 && !nz_o[0]) nz_fall = e;
            if (e == 12) chk("count.rd_at_12", rd_q, 2);
        end
        chk("count.first_tick_edge", first_tick, 10);
        chk("count.tick_period", second_tick - first_tick, 10);
        chk("count.nz0_fall_edge", nz_fall, 31);
        chk("count.saturated", rd_q, 0);

        // ---- load on the decrement edge ----
        do_reset();
        en = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_val = 8'd4;
        cycle("b_ld0");
        ld_en = 1'b0;
        n = 0;
        while (!tick_o && n < 20) begin
            cycle("b_wait");
            n++;
        end
        chk("b.tick_wait", n, 9);
        ld_en = 1'b1; ld_sel = 1'b1; ld_val = 8'd5;
        cycle("b_ld_tick");
        ld_en = 1'b0;
        rd_en = 1'b1; rd_sel = 1'b0;
        cycle("b_rd0");
        chk("b.ch0_decremented", rd_q, 3);
        rd_sel = 1'b1;
        cycle("b_rd1");
        chk("b.ch1_loaded_kept", rd_q, 5);
        rd_en = 1'b0;

        // ---- freeze with en=0 ----
        do_reset();
        en = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_val = 8'd2;
        cycle("c_ld");
        ld_en = 1'b0;
        for (int k = 0; k < 3; k++) cycle("c_run");
        en = 1'b0;
        ticks = 0;
        for (int k = 0; k < 25; k++) begin
            rd_en = (k == 24);
            cycle("c_frozen");
            if (tick_o) ticks++;
        end
        chk("c.frozen_ticks", ticks, 0);
        chk("c.frozen_value", rd_q, 2);
        rd_en = 1'b0; en = 1'b1;
        n = 0;
        do begin
            cycle("c_resume");
            n++;
        end while (!tick_o && n < 20);
        chk("c.resume_edges", n, 6);
        rd_en = 1'b1; rd_sel = 1'b0;
        cycle("c_rd_a");
        cycle("c_rd_b");
        chk("c.after_decrement", rd_q, 1);
        rd_en = 1'b0;

        // ---- asynchronous reset mid-count ----
        do_reset();
        en = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_val = 8'd200;
        cycle("d_ld0");
        ld_sel = 1'b1; ld_val = 8'd50;
        cycle("d_ld1");
        ld_en = 1'b0;
        for (int k = 0; k < 3; k++) cycle("d_run");
        rd_en = 1'b1; rd_sel = 1'b0;
        cycle("d_rd");
        rd_en = 1'b0;
        chk("d.pre_rst_rd_v", rd_v, 1'b1);
        chk("d.pre_rst_rd_q", rd_q, 200);
        #3 rst = 1'b1;
        model_reset();
        #1;
        chk("d.rst_rd_v",   rd_v,   1'b0);
        chk("d.rst_rd_q",   rd_q,   0);
        chk("d.rst_nz_o",   nz_o,   2'b00);
        chk("d.rst_tick_o", tick_o, 1'b0);
        chk("d.rst_tone_o", tone_o, 1'b0);
        #2 rst = 1'b0;
        n = 0;
        do begin
            cycle("d_post");
            n++;
        end while (!tick_o && n < 20);
        chk("d.first_tick_after_rst", n, 10);

        // ---- tone burst from ch1=1 ----
        do_reset();
        en = 1'b1; ld_en = 1'b1; ld_sel = 1'b1; ld_val = 8'd1;
        cycle("e_ld");
        ld_en = 1'b0;
        rises = 0;
        prev_tone = tone_o;
        for (int k = 0; k < 20; k++) begin
            cycle("e_tone");
            if (tone_o && !prev_tone) rises++;
            prev_tone = tone_o;
        end
        chk("e.tone_rises", rises, TONE_ON ? 2 : 0);
        chk("e.tone_idle", tone_o, 1'b0);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            en     = ($urandom_range(0, 9) != 0);
            ld_en  = ($urandom_range(0, 7) == 0);
            ld_sel = 1'($urandom_range(0, 1));
            ld_val = 8'($urandom_range(0, 5));
            rd_en  = 1'($urandom_range(0, 1));
            rd_sel = 1'($urandom_range(0, 1));
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/chip8_timer_bank.md
Name: chip8_timer_bank

Overview:
- Parametrised bank of CHIP-8 style countdown timers. Replaces the interpreter's single free-running delay timer, which decrements every clock.
- Counts at a true tick rate (60 Hz by default) derived from the system clock.
- Supports N channels. Channel 0 is the delay timer (DT) and channel 1 is the sound timer (ST).
- Sits beside the interpreter: Fx15/Fx18 drive the load port, Fx07 drives the read port, and the sound channel can drive an audio pin.

Parameters:
- NUM_CH, 2, number of timer channels (>=1).
- CNT_W, 8, counter width per channel in bits.
- CLK_HZ, 25000000, system clock frequency.
- TICK_HZ, 60, decrement rate. DIV = CLK_HZ/TICK_HZ (integer divide, must be >=2).
- TONE_CH, 1, channel whose non-zero state gates the tone output.
- TONE_DIV, 28409, clocks per half-period of the tone square wave (approx. 440 Hz at 25 MHz).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  prescaler enable. Low freezes the prescaler and all decrements (single-step/debug).
- ld_en  in  1  load strobe, one cycle.
- ld_sel  in  SEL_W  channel to load. SEL_W = max(1,$clog2(NUM_CH)).
- ld_val  in  CNT_W  value to load.
- rd_en  in  1  read strobe.
- rd_sel  in  SEL_W  channel to read.
- rd_q  out  CNT_W  registered read data.
- rd_v  out  1  rd_q valid, single-cycle pulse.
- tick_o  out  1  one-cycle pulse on every prescaler wrap.
- nz_o  out  NUM_CH  per-channel "counter != 0" flags, taken directly from counter registers.
- tone_o  out  1  square wave while TONE_CH counter is non-zero (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - prescaler=0, all counters=0.
  - rd_q=0, rd_v=0, tick_o=0, tone_o=0, tone divider=0.
  - nz_o=0 follows from counters=0.
  - An assert in the middle of a count clears everything immediately. No pending load or read survives reset.
- Prescaler:
  - Counts 0..DIV-1 while en=1, then wraps to 0.
  - tick_o=1 for exactly the cycle after the edge on which the count wraps (registered).
  - en=0 holds the count and suppresses tick_o.
- Decrement: on an edge where the internal tick fires, each channel with counter>0 decrements by 1. A channel at 0 saturates at 0 (never wraps to all-ones).
- Load:
  - On the edge where ld_en=1, counter[ld_sel] <= ld_val.
  - Load has priority over a same-edge decrement on that channel, so the loaded value is not decremented that tick.
  - Other channels still decrement.
  - ld_sel >= NUM_CH: load ignored, no state change.
- Read:
  - rd_en=1 at edge k gives rd_q = counter[rd_sel] value before edge k, and rd_v=1 for cycle k+1. Latency is 1.
  - A read and a load to the same channel on the same edge returns the old value.
  - rd_sel >= NUM_CH returns 0 with rd_v=1.
  - rd_v=0 on every cycle without a read. rd_q holds its last value.
- Back-to-back reads/loads on consecutive cycles are fully supported. There is no busy signal and no backpressure.
- Width rules: counters are CNT_W unsigned. ld_val is used unmodified. DIV arithmetic is done at elaboration time.

Optional Feature:
- Macro: CHIP8_TIMER_TONE_EN.
- Defined:
  - The tone divider counts 0..TONE_DIV-1 while nz_o[TONE_CH]=1, and tone_o toggles on each wrap.
  - When nz_o[TONE_CH] falls, tone_o returns to 0 on the next edge and the divider clears.
  - The first edge after nz rises starts the count from 0.
- Undefined: the tone logic is omitted, but the tone_o port remains and is tied to 0.

Decomposition:
- chip8.vh gains: CHIP8_DT_CH=0, CHIP8_ST_CH=1, CHIP8_TICK_HZ=60, CHIP8_TIMER_W=8.
- One sub-module, timer_prescaler:
  - Parameter DIV; ports clk, rst, en, tick.
  - Reused for the tone divider (DIV=TONE_DIV, en=nz_o[TONE_CH]).
- The channel array and load/read logic stay in chip8_timer_bank.

Test Plan (sim parameters: CLK_HZ=600, TICK_HZ=60 so DIV=10; TONE_DIV=3; NUM_CH=2):
- Load ch0=3 with en=1 -> ch0 reads 3,2,1,0 at successive ticks 10 clocks apart, stays 0 at tick 4, nz_o[0] falls with the 3->...->0 transition; tick_o period is 10 clocks.
- ld_en ch1=5 on the exact edge the tick fires, with ch0=4 -> ch1=5 (not 4), ch0=3.
- rd_en ch0 together with ld_en ch0=9 while ch0=7 -> rd_q=7 and rd_v=1 the next cycle; a read on the following cycle returns 9.
- en=0 for 25 clocks with ch0=2 -> no tick_o, ch0 stays 2. After en=1, the first decrement comes after the remaining prescaler count.
- rst asserted mid-count with ch0=200, ch1=50, prescaler=6 -> the same instant all counters, nz_o, tick_o, tone_o and rd_v read 0; the first tick after release comes 10 clocks later.
- With CHIP8_TIMER_TONE_EN, load ch1=1 -> tone_o toggles every 3 clocks until ch1 hits 0, then reads 0 the next cycle. Without the macro, tone_o stays 0 throughout.
